// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point radix-2 FFT butterfly sequencer.
package fft_pkg;

  localparam int N_POINTS  = 8;
  localparam int N_STAGES  = 3;
  localparam int TW_MJ_IDX = 2;

  typedef logic [2:0] addr_t;
  typedef logic [1:0] tw_idx_t;
  typedef logic [1:0] stage_t;
  typedef logic [1:0] bf_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bf_addr_gen.sv
// Combinational DIT in-place address / twiddle decode for one butterfly.
module bf_addr_gen
  import fft_pkg::*;
(
  input  stage_t  stage,
  input  bf_idx_t bf,
  output addr_t   a_now,
  output addr_t   b_now,
  output tw_idx_t tw_idx,
  output logic    is_mj
);

  addr_t half;
  addr_t j;
  addr_t grp;
  addr_t a;

  // half = 2^stage, a = grp*2*half + j, b = a + half, k = j << (2 - stage)
  always_comb begin
    half   = addr_t'(1) << stage;
    j      = {1'b0, bf} & (half - addr_t'(1));
    grp    = {1'b0, bf} >> stage;
    a      = ((grp << 1) << stage) + j;
    a_now  = a;
    b_now  = a + half;
    tw_idx = tw_idx_t'(j << (2'd2 - stage));
    is_mj  = (tw_idx == tw_idx_t'(TW_MJ_IDX));
  end

endmodule

// File: rtl/bf_issue_ctrl.sv
// Butterfly issue sequencer: 3 stages x 4 butterflies, outstanding count,
// stage barrier, sticky write-back underflow error.
// Optional: BF_CTRL_PERF_EN adds a 16-bit saturating busy-cycle counter.
module bf_issue_ctrl
  import fft_pkg::*;
#(
  parameter int N_STAGES     = 3,
  parameter int BF_PER_STAGE = 4,
  parameter int OUT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        issue_ready,
  input  logic        wb_valid,
  output logic        issue,
  output logic [2:0]  a_now,
  output logic [2:0]  b_now,
  output logic [1:0]  tw_idx,
  output logic        is_mj,
  output logic [1:0]  stage,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef BF_CTRL_PERF_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  localparam bf_idx_t           BF_LAST    = bf_idx_t'(BF_PER_STAGE - 1);
  localparam stage_t            STAGE_LAST = stage_t'(N_STAGES - 1);
  localparam logic [OUT_W-1:0]  OUT_ONE    = 1;

  state_t           state;
  bf_idx_t          bf;
  logic [OUT_W-1:0] outst;
  logic [OUT_W-1:0] outst_nxt;
  logic             wb_err;
  logic             in_issue;
  addr_t            a_raw;
  addr_t            b_raw;
  tw_idx_t          tw_raw;
  logic             mj_raw;

  assign in_issue = (state == ST_ISSUE);
  assign issue    = in_issue && issue_ready;

  bf_addr_gen u_addr_gen (
    .stage  (stage),
    .bf     (bf),
    .a_now  (a_raw),
    .b_now  (b_raw),
    .tw_idx (tw_raw),
    .is_mj  (mj_raw)
  );

  // Operand decode is only presented while issuing; zero otherwise.
  assign a_now  = in_issue ? a_raw  : '0;
  assign b_now  = in_issue ? b_raw  : '0;
  assign tw_idx = in_issue ? tw_raw : '0;
  assign is_mj  = in_issue ? mj_raw : 1'b0;

  // Next outstanding count; a write-back with nothing outstanding is an error.
  always_comb begin
    outst_nxt = outst;
    wb_err    = 1'b0;
    unique case ({issue, wb_valid})
      2'b10:   outst_nxt = outst + OUT_ONE;
      2'b01: begin
        if (outst == '0) wb_err    = 1'b1;
        else             outst_nxt = outst - OUT_ONE;
      end
      default: outst_nxt = outst;
    endcase
  end

  // Sequencing FSM with stage/butterfly/outstanding counters and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      stage <= '0;
      bf    <= '0;
      outst <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      outst <= outst_nxt;
      done  <= 1'b0;
      if (wb_err) err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            busy  <= 1'b1;
            stage <= '0;
            bf    <= '0;
          end
        end
        ST_ISSUE: begin
          if (issue_ready) begin
            bf <= bf + bf_idx_t'(1);
            if (bf == BF_LAST) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Barrier: leave on the edge where the last write-back retires.
          if (outst_nxt == '0) begin
            if (stage == STAGE_LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_ISSUE;
              stage <= stage + stage_t'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          stage <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BF_CTRL_PERF_EN
  // Saturating count of busy cycles, restarted by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bf_issue_ctrl.sv
// Self-checking bench for bf_issue_ctrl: directed transforms with a
// table of expected butterfly issues and a reset-state vector table.
module tb_bf_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        issue_ready;
  logic        wb_valid;
  logic        issue;
  logic [2:0]  a_now;
  logic [2:0]  b_now;
  logic [1:0]  tw_idx;
  logic        is_mj;
  logic [1:0]  stage;
  logic        busy;
  logic        done;
  logic        err;
`ifdef BF_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int a;
    int b;
    int tw;
    int mj;
    int stg;
  } iss_t;

  iss_t exp_seq[12];

  bf_issue_ctrl #(.N_STAGES(3), .BF_PER_STAGE(4), .OUT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .issue       (issue),
    .a_now       (a_now),
    .b_now       (b_now),
    .tw_idx      (tw_idx),
    .is_mj       (is_mj),
    .stage       (stage),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef BF_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_err);
    string nm[9];
    int    act[9];
    int    ex[9];
    nm  = '{"issue", "a_now", "b_now", "tw_idx", "is_mj", "stage", "busy", "done", "err"};
    act = '{int'(issue), int'(a_now), int'(b_now), int'(tw_idx), int'(is_mj),
            int'(stage), int'(busy), int'(done), int'(err)};
    ex  = '{0, 0, 0, 0, 0, 0, 0, 0, exp_err};
    for (int i = 0; i < 9; i++) chk({tag, " ", nm[i]}, act[i], ex[i]);
  endtask

  task automatic run_xfer(input string tag, input int wb_dly, input int hold_idx,
                          input int hold_extra, input int stall_after, input int stall_len,
                          input int xstart_cyc, input int rst_idx);
    bit sched[512];
    int last_wb[3];
    int n_iss      = 0;
    int n_done     = 0;
    int busy_cnt   = 0;
    int stall_left = 0;
    int cyc;
    int d;
    bit stalled    = 1'b0;
    bit finished   = 1'b0;
    bit was_rst    = 1'b0;
    bit rst_now;
    bit exp_err;
    for (int i = 0; i < 512; i++) sched[i] = 1'b0;
    for (int i = 0; i < 3; i++) last_wb[i] = 0;

    start = 1'b1; issue_ready = 1'b1; wb_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 400) begin
      rst_now = 1'b0;
      if (stall_after >= 0 && !stalled && n_iss == stall_after) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      issue_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      wb_valid = sched[cyc];
      start    = (cyc == xstart_cyc);
      #1;
      if (issue) begin
        if (n_iss >= 12) begin
          chk({tag, " issue count"}, n_iss + 1, 12);
        end else begin
          chk({tag, " a_now"},  int'(a_now),  exp_seq[n_iss].a);
          chk({tag, " b_now"},  int'(b_now),  exp_seq[n_iss].b);
          chk({tag, " tw_idx"}, int'(tw_idx), exp_seq[n_iss].tw);
          chk({tag, " is_mj"},  int'(is_mj),  exp_seq[n_iss].mj);
          chk({tag, " stage"},  int'(stage),  exp_seq[n_iss].stg);
          if (n_iss == 0)
            chk({tag, " first issue cycle"}, cyc, 1);
          else if (n_iss % 4 == 0)
            chk({tag, " barrier issue cycle"}, cyc, last_wb[n_iss/4 - 1] + 1);
          d = wb_dly + ((n_iss == hold_idx) ? hold_extra : 0);
          if (cyc + d < 512) sched[cyc + d] = 1'b1;
          if (cyc + d > last_wb[n_iss/4]) last_wb[n_iss/4] = cyc + d;
          if (n_iss == rst_idx) rst_now = 1'b1;
        end
        n_iss++;
      end else if (busy) begin
        chk({tag, " stage hold"}, int'(stage), (n_iss == 0) ? 0 : (n_iss - 1) / 4);
        if (!issue_ready && n_iss < 12) begin
          chk({tag, " stall a_now"}, int'(a_now), exp_seq[n_iss].a);
          chk({tag, " stall b_now"}, int'(b_now), exp_seq[n_iss].b);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        chk({tag, " done cycle"}, cyc, last_wb[2] + 1);
        chk({tag, " busy at done"}, int'(busy), 0);
`ifdef BF_CTRL_PERF_EN
        chk({tag, " perf_cycles"}, int'(perf_cycles), busy_cnt);
`endif
        finished = 1'b1;
      end
      if (rst_now) begin
        rst_n = 1'b0;
        wb_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        issue_ready = 1'b1;
        wb_valid = sched[cyc];
        #1;
        check_outputs({tag, " post-reset"}, 0);
        exp_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
          wb_valid = sched[cyc];
          exp_err |= sched[cyc];
          @(posedge clk); #1;
          cyc++;
        end
        wb_valid = 1'b0;
        #1;
        chk({tag, " late wb err"}, int'(err), int'(exp_err));
        chk({tag, " late wb busy"}, int'(busy), 0);
        finished = 1'b1;
        was_rst  = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!finished) chk({tag, " completed within bound"}, 0, 1);
    if (!was_rst) begin
      wb_valid = 1'b0;
      start    = 1'b0;
      #1;
      chk({tag, " idle done"},  int'(done),  0);
      chk({tag, " idle busy"},  int'(busy),  0);
      chk({tag, " idle issue"}, int'(issue), 0);
      chk({tag, " total issues"}, n_iss, 12);
      chk({tag, " done pulses"}, n_done, 1);
      chk({tag, " err"}, int'(err), 0);
      chk({tag, " busy cycles"}, busy_cnt, last_wb[2]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; issue_ready = 1'b1; wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_seq[0]  = '{0, 1, 0, 0, 0};
    exp_seq[1]  = '{2, 3, 0, 0, 0};
    exp_seq[2]  = '{4, 5, 0, 0, 0};
    exp_seq[3]  = '{6, 7, 0, 0, 0};
    exp_seq[4]  = '{0, 2, 0, 0, 1};
    exp_seq[5]  = '{1, 3, 2, 1, 1};
    exp_seq[6]  = '{4, 6, 0, 0, 1};
    exp_seq[7]  = '{5, 7, 2, 1, 1};
    exp_seq[8]  = '{0, 4, 0, 0, 2};
    exp_seq[9]  = '{1, 5, 1, 0, 2};
    exp_seq[10] = '{2, 6, 2, 1, 2};
    exp_seq[11] = '{3, 7, 3, 0, 2};

    rst_n = 1'b0; start = 1'b0; issue_ready = 1'b1; wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0);
`ifdef BF_CTRL_PERF_EN
    chk("reset perf_cycles", int'(perf_cycles), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_xfer("free",    3, -1,  0, -1, 0, -1, -1);
    @(posedge clk); #1;
    run_xfer("wb2",     2, -1,  0, -1, 0, -1, -1);
    @(posedge clk); #1;
    run_xfer("barrier", 3,  3, 10, -1, 0, -1, -1);
    @(posedge clk); #1;
    run_xfer("stall",   3, -1,  0,  2, 2, -1, -1);
    @(posedge clk); #1;
    run_xfer("xstart",  3, -1,  0, -1, 0,  5, -1);
    @(posedge clk); #1;
    run_xfer("midrst",  3, -1,  0, -1, 0, -1,  5);

    do_reset();
    #1;
    check_outputs("reset2", 0);

    // Write-back while idle sets err, which then stays set.
    wb_valid = 1'b1;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    #1;
    chk("idle wb err", int'(err), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle wb err sticky", int'(err), 1);
    chk("idle wb busy", int'(busy), 0);

    do_reset();
    #1;
    check_outputs("reset3", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
